if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port PcStall  input  1  hazard-detect stall; hold PC and the IF/ID register.
REQ-004 SHALL have port Redirect  input  1  taken branch/jump from a later stage; squash and reload PC.
REQ-005 SHALL have port RedirectPc  input  16  branch/jump target.
REQ-006 SHALL have port Halt  input  1  HALT decoded; stop fetching.
REQ-007 SHALL have port ImemRdata  input  16  instruction memory read data, valid when ImemDone=1.
REQ-008 SHALL have port ImemDone  input  1  read complete, same cycle as a hit or N>=1 cycles later.
REQ-009 SHALL have port ImemRd  output  1  read request, held high until ImemDone.
REQ-010 SHALL have port ImemAddr  output  16  read address, equal to the current PC.
REQ-011 SHALL have port Instr  output  16  IF/ID instruction register.
REQ-012 SHALL have port PcPlus2  output  16  IF/ID PC+2 register.
REQ-013 SHALL have port Valid  output  1  IF/ID holds a real instruction.
REQ-014 SHALL have port Err  output  1  sticky fetch error.

Function
REQ-015 SHALL implement states FETCH, WAIT, HOLD, DRAIN and HALTED, with registered PC, IF/ID register {Instr, PcPlus2, Valid} and a 16-bit hold buffer.
REQ-016 In FETCH, SHALL drive ImemRd=1 and ImemAddr=PC; ImemDone=0 -> WAIT.
REQ-017 In WAIT, SHALL keep ImemRd=1 and ImemAddr stable; ImemDone=1 -> data accepted.
REQ-018 On accept with PcStall=0, SHALL set {Instr, PcPlus2, Valid} <= {ImemRdata, PC+2, 1}, set PC <= PC+2 and go to FETCH, giving 1-cycle latency on a hit.
REQ-019 On accept with PcStall=1, SHALL load the hold buffer, leave IF/ID unchanged and go to HOLD.
REQ-020 In HOLD, SHALL drive ImemRd=0; when PcStall falls, SHALL load IF/ID from the buffer, set PC <= PC+2 and go to FETCH.
REQ-021 With PcStall=1 and no accept, SHALL hold PC and IF/ID.
REQ-022 Redirect=1 SHALL have the highest priority: IF/ID <= {16'h0800 (NOP), 0, 0} and PC <= RedirectPc, regardless of PcStall.
REQ-023 On Redirect in FETCH or HOLD, SHALL go to FETCH and discard the buffer; in WAIT with ImemDone=0, SHALL go to DRAIN.
REQ-024 In DRAIN, SHALL keep ImemRd=1 at the old address, discard data on ImemDone and then go to FETCH at the new PC.
REQ-025 Halt=1 with Redirect=0 SHALL load the NOP bubble into IF/ID; from FETCH or HOLD go to HALTED, from WAIT go to DRAIN and then HALTED.
REQ-026 In HALTED, SHALL drive ImemRd=0, freeze PC and keep Valid=0; only rst exits.
REQ-027 Redirect and Halt asserted together SHALL take the redirect (the older instruction wins).
REQ-028 PC arithmetic SHALL be 16-bit modulo: 16'hFFFE + 2 = 16'h0000, with no error.

Reset
REQ-029 On rst=1 at a clock edge, SHALL set PC=0, state=FETCH, Instr=16'h0800, PcPlus2=0, Valid=0, Err=0 and clear the buffer.
REQ-030 Reset mid-WAIT SHALL abandon the outstanding read; ImemRd SHALL be 1 at address 0 in the first cycle after reset.

Configuration
REQ-031 With macro IF_ALIGN_CHECK_EN defined, a PC or RedirectPc with bit0=1 at the time it is issued SHALL set Err=1 (sticky), load a bubble and go to HALTED.
REQ-032 Without IF_ALIGN_CHECK_EN, bit0 of PC SHALL be forced to 0 and Err SHALL be tied to 0.

Verification
REQ-033 Reset, then ImemDone=1 every cycle with data 16'h4001, 16'h4002 -> Instr=16'h4001/PcPlus2=2 after the first edge and 16'h4002/4 after the second, Valid=1.
REQ-034 Miss: ImemDone held low 3 cycles at PC=4 -> ImemRd=1 and ImemAddr=4 for 4 cycles, IF/ID unchanged until the data edge.
REQ-035 PcStall=1 for 2 cycles during a hit at PC=6 -> HOLD, Instr unchanged; after release Instr=fetched word, PC=8.
REQ-036 Redirect=1 with RedirectPc=16'h0100 during WAIT -> Instr=16'h0800 and Valid=0; returned data is discarded; the next ImemAddr is 16'h0100.
REQ-037 Halt=1 -> Valid=0 and ImemRd=0 thereafter; PC frozen until rst.
REQ-038 With IF_ALIGN_CHECK_EN: RedirectPc=16'h0103 -> Err=1, HALTED; without the macro: ImemAddr=16'h0102, Err=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem handshake, IF/ID register; 1-cycle hit latency, PcStall holds PC and IF/ID.
// Optional IF_ALIGN_CHECK_EN: an odd redirect target raises sticky Err and halts; otherwise bit0 of PC is forced to 0.
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        PcStall,
  input  logic        Redirect,
  input  logic [15:0] RedirectPc,
  input  logic        Halt,
  input  logic [15:0] ImemRdata,
  input  logic        ImemDone,
  output logic        ImemRd,
  output logic [15:0] ImemAddr,
  output logic [15:0] Instr,
  output logic [15:0] PcPlus2,
  output logic        Valid,
  output logic        Err
);

  localparam logic [15:0] NOP = 16'h0800;

  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] buf_q, buf_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_plus2_q, pc_plus2_d;
  logic [15:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        rd_q, rd_d;
  logic        halt_pend_q, halt_pend_d;
  logic [15:0] pc_inc;
  logic [15:0] redir_pc;
  logic        redir_bad;
  logic        outstanding;

  always_comb begin
    pc_inc      = pc_q + 16'd2;
`ifdef IF_ALIGN_CHECK_EN
    redir_pc    = RedirectPc;
    redir_bad   = RedirectPc[0];
`else
    redir_pc    = {RedirectPc[15:1], 1'b0};
    redir_bad   = 1'b0;
`endif
    // A read still in flight must be drained before a new address may be issued.
    outstanding = ((state_q == S_WAIT) || (state_q == S_DRAIN)) && !ImemDone;

    state_d     = state_q;
    pc_d        = pc_q;
    buf_d       = buf_q;
    instr_d     = instr_q;
    pc_plus2_d  = pc_plus2_q;
    valid_d     = valid_q;
    err_d       = err_q;
    halt_pend_d = halt_pend_q;

    if (state_q != S_HALTED) begin
      if (Redirect) begin
        instr_d    = NOP;
        pc_plus2_d = 16'h0000;
        valid_d    = 1'b0;
        buf_d      = 16'h0000;
        if (redir_bad) begin
          err_d       = 1'b1;
          halt_pend_d = 1'b1;
          state_d     = outstanding ? S_DRAIN : S_HALTED;
        end else begin
          pc_d        = redir_pc;
          halt_pend_d = 1'b0;
          state_d     = outstanding ? S_DRAIN : S_FETCH;
        end
      end else if (Halt) begin
        instr_d     = NOP;
        pc_plus2_d  = 16'h0000;
        valid_d     = 1'b0;
        buf_d       = 16'h0000;
        halt_pend_d = 1'b1;
        state_d     = outstanding ? S_DRAIN : S_HALTED;
      end else begin
        case (state_q)
          S_FETCH, S_WAIT: begin
            if (ImemDone) begin
              if (!PcStall) begin
                instr_d    = ImemRdata;
                pc_plus2_d = pc_inc;
                valid_d    = 1'b1;
                pc_d       = pc_inc;
                state_d    = S_FETCH;
              end else begin
                buf_d   = ImemRdata;
                state_d = S_HOLD;
              end
            end else begin
              state_d = S_WAIT;
            end
          end
          S_HOLD: begin
            if (!PcStall) begin
              instr_d    = buf_q;
              pc_plus2_d = pc_inc;
              valid_d    = 1'b1;
              pc_d       = pc_inc;
              state_d    = S_FETCH;
            end
          end
          S_DRAIN: begin
            if (ImemDone) begin
              state_d = halt_pend_q ? S_HALTED : S_FETCH;
            end
          end
          default: ;
        endcase
      end
    end

    rd_d   = (state_d == S_FETCH) || (state_d == S_WAIT) || (state_d == S_DRAIN);
    // While draining, the abandoned read keeps its original address.
    addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      pc_q        <= 16'h0000;
      buf_q       <= 16'h0000;
      instr_q     <= NOP;
      pc_plus2_q  <= 16'h0000;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      rd_q        <= 1'b1;
      addr_q      <= 16'h0000;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_q       <= buf_d;
      instr_q     <= instr_d;
      pc_plus2_q  <= pc_plus2_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign ImemRd   = rd_q;
  assign ImemAddr = addr_q;
  assign Instr    = instr_q;
  assign PcPlus2  = pc_plus2_q;
  assign Valid    = valid_q;
  assign Err      = err_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run against a program-order fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, PcStall, Redirect, Halt, ImemDone;
  logic [15:0] RedirectPc, ImemRdata;
  logic        ImemRd, Valid, Err;
  logic [15:0] ImemAddr, Instr, PcPlus2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk), .rst(rst), .PcStall(PcStall), .Redirect(Redirect), .RedirectPc(RedirectPc),
    .Halt(Halt), .ImemRdata(ImemRdata), .ImemDone(ImemDone), .ImemRd(ImemRd),
    .ImemAddr(ImemAddr), .Instr(Instr), .PcPlus2(PcPlus2), .Valid(Valid), .Err(Err)
  );

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    PcStall = 0; Redirect = 0; RedirectPc = 0; Halt = 0; ImemDone = 0; ImemRdata = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset();
    n_checks++; if (Instr !== 16'h0800) begin n_fail++; $display("FAIL reset_instr got %h want 0800", Instr); end
    n_checks++; if (PcPlus2 !== 16'h0000) begin n_fail++; $display("FAIL reset_pcplus2 got %h want 0000", PcPlus2); end
    n_checks++; if (Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", Valid); end
    n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", Err); end
    n_checks++; if (ImemRd !== 1'b1 || ImemAddr !== 16'h0000) begin n_fail++; $display("FAIL reset_fetch got rd=%b addr=%h want rd=1 addr=0000", ImemRd, ImemAddr); end
  endtask

  task automatic test_hit;
    ImemDone = 1; ImemRdata = 16'h4001;
    step();
    n_checks++; if (Instr !== 16'h4001 || PcPlus2 !== 16'h0002 || Valid !== 1'b1) begin n_fail++; $display("FAIL hit1 got %h/%h/%b want 4001/0002/1", Instr, PcPlus2, Valid); end
    n_checks++; if (ImemAddr !== 16'h0002) begin n_fail++; $display("FAIL hit1_addr got %h want 0002", ImemAddr); end
    ImemRdata = 16'h4002;
    step();
    n_checks++; if (Instr !== 16'h4002 || PcPlus2 !== 16'h0004 || Valid !== 1'b1) begin n_fail++; $display("FAIL hit2 got %h/%h/%b want 4002/0004/1", Instr, PcPlus2, Valid); end
  endtask

  task automatic test_miss;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (ImemRd !== 1'b1 || ImemAddr !== 16'h0004 || Instr !== 16'h4002) begin n_fail++; $display("FAIL miss_cycle%0d got rd=%b addr=%h instr=%h want 1/0004/4002", i, ImemRd, ImemAddr, Instr); end
      ImemDone = (i == 3); ImemRdata = 16'h4003;
      step();
    end
    n_checks++; if (Instr !== 16'h4003 || PcPlus2 !== 16'h0006 || Valid !== 1'b1) begin n_fail++; $display("FAIL miss_data got %h/%h/%b want 4003/0006/1", Instr, PcPlus2, Valid); end
  endtask

  task automatic test_stall;
    PcStall = 1; ImemDone = 1; ImemRdata = 16'h4004;
    step();
    n_checks++; if (Instr !== 16'h4003 || ImemRd !== 1'b0) begin n_fail++; $display("FAIL stall_hold1 got instr=%h rd=%b want 4003/0", Instr, ImemRd); end
    ImemDone = 0; ImemRdata = 16'hBEEF;
    step();
    n_checks++; if (Instr !== 16'h4003 || PcPlus2 !== 16'h0006) begin n_fail++; $display("FAIL stall_hold2 got %h/%h want 4003/0006", Instr, PcPlus2); end
    PcStall = 0;
    step();
    n_checks++; if (Instr !== 16'h4004 || PcPlus2 !== 16'h0008 || Valid !== 1'b1) begin n_fail++; $display("FAIL stall_release got %h/%h/%b want 4004/0008/1", Instr, PcPlus2, Valid); end
    n_checks++; if (ImemRd !== 1'b1 || ImemAddr !== 16'h0008) begin n_fail++; $display("FAIL stall_next_pc got rd=%b addr=%h want 1/0008", ImemRd, ImemAddr); end
  endtask

  task automatic test_redirect;
    ImemDone = 0;
    step();
    Redirect = 1; RedirectPc = 16'h0100;
    step();
    Redirect = 0;
    n_checks++; if (Instr !== 16'h0800 || Valid !== 1'b0 || PcPlus2 !== 16'h0000) begin n_fail++; $display("FAIL redir_bubble got %h/%h/%b want 0800/0000/0", Instr, PcPlus2, Valid); end
    n_checks++; if (ImemRd !== 1'b1 || ImemAddr !== 16'h0008) begin n_fail++; $display("FAIL redir_drain got rd=%b addr=%h want 1/0008", ImemRd, ImemAddr); end
    ImemDone = 1; ImemRdata = 16'hDEAD;
    step();
    n_checks++; if (Instr !== 16'h0800 || Valid !== 1'b0) begin n_fail++; $display("FAIL redir_discard got %h/%b want 0800/0", Instr, Valid); end
    n_checks++; if (ImemAddr !== 16'h0100 || ImemRd !== 1'b1) begin n_fail++; $display("FAIL redir_target got rd=%b addr=%h want 1/0100", ImemRd, ImemAddr); end
    ImemRdata = 16'h5000;
    step();
    n_checks++; if (Instr !== 16'h5000 || PcPlus2 !== 16'h0102 || Valid !== 1'b1) begin n_fail++; $display("FAIL redir_first got %h/%h/%b want 5000/0102/1", Instr, PcPlus2, Valid); end
  endtask

  task automatic test_wrap;
    ImemDone = 0; Redirect = 1; RedirectPc = 16'hFFFE;
    step();
    Redirect = 0;
    n_checks++; if (ImemAddr !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_addr got %h want fffe", ImemAddr); end
    ImemDone = 1; ImemRdata = 16'h6000;
    step();
    n_checks++; if (Instr !== 16'h6000 || PcPlus2 !== 16'h0000 || ImemAddr !== 16'h0000 || Err !== 1'b0) begin n_fail++; $display("FAIL wrap_result got %h/%h/%h err=%b want 6000/0000/0000 err=0", Instr, PcPlus2, ImemAddr, Err); end
  endtask

  task automatic test_align;
    ImemDone = 0; Redirect = 1; RedirectPc = 16'h0103;
    step();
    Redirect = 0;
`ifdef IF_ALIGN_CHECK_EN
    n_checks++; if (Err !== 1'b1 || ImemRd !== 1'b0 || Valid !== 1'b0) begin n_fail++; $display("FAIL align_err got err=%b rd=%b valid=%b want 1/0/0", Err, ImemRd, Valid); end
    ImemDone = 1;
    step();
    n_checks++; if (Err !== 1'b1 || ImemRd !== 1'b0) begin n_fail++; $display("FAIL align_sticky got err=%b rd=%b want 1/0", Err, ImemRd); end
`else
    n_checks++; if (ImemAddr !== 16'h0102 || Err !== 1'b0 || ImemRd !== 1'b1) begin n_fail++; $display("FAIL align_force got addr=%h err=%b rd=%b want 0102/0/1", ImemAddr, Err, ImemRd); end
    ImemDone = 1; ImemRdata = 16'h7000;
    step();
    n_checks++; if (Instr !== 16'h7000 || PcPlus2 !== 16'h0104) begin n_fail++; $display("FAIL align_fetch got %h/%h want 7000/0104", Instr, PcPlus2); end
`endif
  endtask

  task automatic test_halt;
    do_reset();
    ImemDone = 1; ImemRdata = 16'h4001;
    step();
    ImemDone = 0;
    step();
    Halt = 1;
    step();
    Halt = 0;
    n_checks++; if (Valid !== 1'b0 || Instr !== 16'h0800 || ImemRd !== 1'b1 || ImemAddr !== 16'h0002) begin n_fail++; $display("FAIL halt_drain got valid=%b instr=%h rd=%b addr=%h want 0/0800/1/0002", Valid, Instr, ImemRd, ImemAddr); end
    ImemDone = 1; ImemRdata = 16'hDEAD;
    step();
    n_checks++; if (ImemRd !== 1'b0 || Valid !== 1'b0) begin n_fail++; $display("FAIL halt_enter got rd=%b valid=%b want 0/0", ImemRd, Valid); end
    for (int i = 0; i < 6; i++) begin
      Redirect = 1'($urandom); RedirectPc = 16'($urandom) & 16'hFFFE; ImemDone = 1'($urandom);
      PcStall = 1'($urandom); Halt = 1'($urandom);
      step();
      n_checks++; if (ImemRd !== 1'b0 || Valid !== 1'b0 || ImemAddr !== 16'h0002) begin n_fail++; $display("FAIL halt_frozen%0d got rd=%b valid=%b addr=%h want 0/0/0002", i, ImemRd, Valid, ImemAddr); end
    end
    do_reset();
    n_checks++; if (ImemRd !== 1'b1 || ImemAddr !== 16'h0000) begin n_fail++; $display("FAIL halt_exit got rd=%b addr=%h want 1/0000", ImemRd, ImemAddr); end
  endtask

  task automatic test_reset_mid_wait;
    ImemDone = 1; ImemRdata = 16'h4001;
    step();
    ImemDone = 0;
    step();
    rst = 1;
    step();
    rst = 0;
    n_checks++; if (ImemRd !== 1'b1 || ImemAddr !== 16'h0000 || Valid !== 1'b0 || Instr !== 16'h0800) begin n_fail++; $display("FAIL rst_wait got rd=%b addr=%h valid=%b instr=%h want 1/0000/0/0800", ImemRd, ImemAddr, Valid, Instr); end
    ImemDone = 1; ImemRdata = 16'h4321;
    step();
    n_checks++; if (Instr !== 16'h4321 || PcPlus2 !== 16'h0002) begin n_fail++; $display("FAIL rst_wait_fetch got %h/%h want 4321/0002", Instr, PcPlus2); end
  endtask

  // Program-order model: each newly delivered instruction must be mem[next PC]; a redirect restarts the stream.
  task automatic test_random;
    logic [15:0] exp_pc, req_addr, p_instr, p_pp2, tgt;
    logic        p_valid, req_act, redir, stall, changed;
    int          lat, cnt, retired;
    do_reset();
    exp_pc = 0; req_act = 0; req_addr = 0; lat = 0; cnt = 0; retired = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ImemRd) begin
        if (!req_act || ImemAddr != req_addr) begin
          req_act = 1; req_addr = ImemAddr; lat = $urandom_range(0, 2); cnt = 0;
        end
        ImemDone  = (cnt == lat);
        ImemRdata = mem_f(ImemAddr);
        cnt++;
        if (ImemDone) req_act = 0;
      end else begin
        ImemDone = 0; ImemRdata = 16'($urandom); req_act = 0;
      end
      stall = ($urandom_range(0, 9) < 3);
      redir = ($urandom_range(0, 99) < 5);
      tgt   = 16'($urandom) & 16'hFFFE;
      PcStall = stall; Redirect = redir; RedirectPc = tgt;
      p_instr = Instr; p_pp2 = PcPlus2; p_valid = Valid;
      step();
      changed = (Instr !== p_instr) || (PcPlus2 !== p_pp2) || (Valid !== p_valid);
      if (redir) begin
        n_checks++; if (Instr !== 16'h0800 || PcPlus2 !== 16'h0000 || Valid !== 1'b0) begin n_fail++; $display("FAIL rnd_redir cyc%0d got %h/%h/%b want 0800/0000/0", cyc, Instr, PcPlus2, Valid); end
        exp_pc = tgt;
      end else if (changed) begin
        n_checks++; if (stall) begin n_fail++; $display("FAIL rnd_stall cyc%0d got %h/%h/%b want %h/%h/%b", cyc, Instr, PcPlus2, Valid, p_instr, p_pp2, p_valid); end
        n_checks++; if (Valid !== 1'b1 || Instr !== mem_f(exp_pc) || PcPlus2 !== exp_pc + 16'd2) begin n_fail++; $display("FAIL rnd_order cyc%0d got %h/%h/%b want %h/%h/1", cyc, Instr, PcPlus2, Valid, mem_f(exp_pc), exp_pc + 16'd2); end
        exp_pc = exp_pc + 16'd2;
        retired++;
      end
    end
    idle_inputs();
    n_checks++; if (retired < 100) begin n_fail++; $display("FAIL rnd_progress got %0d retired want at least 100", retired); end
    n_checks++; if (Err !== 1'b0) begin n_fail++; $display("FAIL rnd_err got %b want 0", Err); end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_hit();
    test_miss();
    test_stall();
    test_redirect();
    test_wrap();
    test_align();
    test_halt();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
